// File: rtl/alu_acc_seq_if.sv
// Operand/result bundle between the bus operand registers, control unit and alu_acc_seq.
// The master side issues start/op/operands; the slave side returns status and the accumulator.
interface alu_acc_seq_if #(
    parameter int WIDTH = 4
);
    logic               start;
    logic [2:0]         op;
    logic [WIDTH-1:0]   a_data;
    logic [WIDTH-1:0]   b_data;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] acc_data;
    logic               sign_flag;
    logic               zero_flag;
    logic               dz_flag;

    modport master (
        output start, op, a_data, b_data,
        input  busy, done, acc_data, sign_flag, zero_flag, dz_flag
    );

    modport slave (
        input  start, op, a_data, b_data,
        output busy, done, acc_data, sign_flag, zero_flag, dz_flag
    );
endinterface

// File: rtl/alu_acc_seq.sv
// Sequential ALU/accumulator: single-cycle add/sub/and, plus sequenced shift-add
// multiply and restoring divide into a double-width {acc_high, acc_low} accumulator.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// RUN   | stepping MUL/DIV, one step per clock, WIDTH steps total
module alu_acc_seq #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_acc_seq_if.slave bus
);
    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    step_cnt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] b_r;
    logic [AW-1:0]    acc;
    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic             sign_r;
    logic             zero_r;

    logic [WIDTH-1:0] acc_high;
    logic [WIDTH-1:0] acc_low;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [AW-1:0]    single_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_min;
    logic [WIDTH+1:0] div_trial;
    logic [AW-1:0]    step_next;
    logic             multi_cycle;

    assign acc_high = acc[AW-1:WIDTH];
    assign acc_low  = acc[WIDTH-1:0];

    // DIV by zero never enters RUN; it returns the dividend as remainder at once.
    assign multi_cycle = (bus.op == OP_MUL) ||
                         ((bus.op == OP_DIV) && (bus.b_data != '0));

    always_comb begin
        add_sum    = {1'b0, bus.a_data} + {1'b0, bus.b_data};
        sub_diff   = {1'b0, bus.a_data} - {1'b0, bus.b_data};
        single_res = '0;
        case (bus.op)
            OP_ADD:  single_res = {{(WIDTH-1){1'b0}}, add_sum[WIDTH], add_sum[WIDTH-1:0]};
            OP_SUB:  single_res = {{WIDTH{sub_diff[WIDTH]}}, sub_diff[WIDTH-1:0]};
            OP_AND:  single_res = {{WIDTH{1'b0}}, bus.a_data & bus.b_data};
            OP_DIV:  single_res = {bus.a_data, {WIDTH{1'b1}}};
            default: single_res = '0;
        endcase
    end

    always_comb begin
        mul_sum   = acc_low[0] ? ({1'b0, acc_high} + {1'b0, b_r}) : {1'b0, acc_high};
        div_min   = {acc_high, acc_low[WIDTH-1]};
        div_trial = {1'b0, div_min} - {2'b00, b_r};
        step_next = '0;
        if (op_r == OP_MUL) begin
            step_next = {mul_sum, acc_low[WIDTH-1:1]};
        end else if (div_trial[WIDTH+1]) begin
            step_next = {div_min[WIDTH-1:0], acc_low[WIDTH-2:0], 1'b0};
        end else begin
            step_next = {div_trial[WIDTH-1:0], acc_low[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            step_cnt <= '0;
            op_r     <= OP_ADD;
            b_r      <= '0;
            acc      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            sign_r   <= 1'b0;
            zero_r   <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r <= bus.op;
                        b_r  <= bus.b_data;
                        if (multi_cycle) begin
                            acc      <= {{WIDTH{1'b0}}, bus.a_data};
                            step_cnt <= '0;
                            busy_r   <= 1'b1;
                            state    <= RUN;
                        end else begin
                            acc    <= single_res;
                            done_r <= 1'b1;
                            sign_r <= single_res[AW-1];
                            zero_r <= (single_res == '0);
                            if (bus.op == OP_DIV) dz_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc <= step_next;
                    if (step_cnt == LAST_STEP) begin
                        step_cnt <= '0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        sign_r   <= step_next[AW-1];
                        zero_r   <= (step_next == '0);
                        if (op_r == OP_DIV) dz_r <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.acc_data  = acc;
    assign bus.sign_flag = sign_r;
    assign bus.zero_flag = zero_r;
    assign bus.dz_flag   = dz_r;
endmodule
